// File: rtl/bd_exc_ctrl_if.sv
// Pipeline/CP0 signal bundle for the precise-exception sequencer.
// slave = sequencer side, master = pipeline/CP0 side.
interface bd_exc_ctrl_if;
   logic        BD_D;
   logic        valid_D;
   logic        stall_E;
   logic [31:0] PC_M;
   logic [31:0] PC_E;
   logic        exc_M;
   logic [4:0]  exccode_M;
   logic        eret_M;
   logic [5:0]  hw_int;
   logic [5:0]  im;
   logic        ie;
   logic        exl;
   logic [31:0] epc_cur;
   logic        cp0_exc_we;
   logic [31:0] epc_out;
   logic        bd_out;
   logic [4:0]  exccode_out;
   logic        exl_clr;
   logic        flush_all;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   modport slave (
      input  BD_D, valid_D, stall_E, PC_M, PC_E, exc_M, exccode_M, eret_M,
             hw_int, im, ie, exl, epc_cur,
      output cp0_exc_we, epc_out, bd_out, exccode_out, exl_clr, flush_all,
             pc_redirect, redirect_pc, busy
   );

   modport master (
      output BD_D, valid_D, stall_E, PC_M, PC_E, exc_M, exccode_M, eret_M,
             hw_int, im, ie, exl, epc_cur,
      input  cp0_exc_we, epc_out, bd_out, exccode_out, exl_clr, flush_all,
             pc_redirect, redirect_pc, busy
   );
endinterface

// File: rtl/bd_exc_ctrl.sv
// Precise exception/ERET sequencer: decides at M, strobes CP0 and redirect one cycle later,
// then holds flush for DRAIN_CYC cycles; no backpressure, events are ignored while busy.
module bd_exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter int          DRAIN_CYC  = 2
) (
   input logic          clk,
   input logic          reset,
   bd_exc_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ENTER, RET, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        bd_E_q, val_E_q, bd_M_q, val_M_q;
   logic [2:0]  drain_cnt_q, drain_cnt_d;
   logic [31:0] epc_q, epc_d;
   logic        bd_q, bd_d;
   logic [4:0]  code_q, code_d;

   logic        int_req, take_exc, take_int, take_ret;
   logic        victim_bd;
   logic [31:0] victim_pc;
   logic        flush;

   assign flush    = (state_q != IDLE);
   assign int_req  = bus.ie & ~bus.exl & (|(bus.hw_int & bus.im));
   assign take_exc = bus.exc_M & val_M_q;
   assign take_int = int_req & (val_M_q | val_E_q);
   assign take_ret = bus.eret_M & val_M_q;

   // An interrupt with M empty lands on the E instruction; exceptions always have val_M set.
   assign victim_bd = val_M_q ? bd_M_q : bd_E_q;
   assign victim_pc = val_M_q ? bus.PC_M : bus.PC_E;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bd_E_q  <= 1'b0;
         val_E_q <= 1'b0;
         bd_M_q  <= 1'b0;
         val_M_q <= 1'b0;
      end else if (flush) begin
         bd_E_q  <= 1'b0;
         val_E_q <= 1'b0;
         bd_M_q  <= 1'b0;
         val_M_q <= 1'b0;
      end else if (!bus.stall_E) begin
         bd_E_q  <= bus.BD_D;
         val_E_q <= bus.valid_D;
         bd_M_q  <= bd_E_q;
         val_M_q <= val_E_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         drain_cnt_q <= 3'd0;
         epc_q       <= 32'd0;
         bd_q        <= 1'b0;
         code_q      <= 5'd0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         epc_q       <= epc_d;
         bd_q        <= bd_d;
         code_q      <= code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      epc_d       = epc_q;
      bd_d        = bd_q;
      code_d      = code_q;
      unique case (state_q)
         IDLE: begin
            if (take_exc || take_int) begin
               state_d = ENTER;
               epc_d   = victim_bd ? (victim_pc - 32'd4) : victim_pc;
               bd_d    = victim_bd;
               code_d  = take_exc ? bus.exccode_M : 5'd0;
            end else if (take_ret) begin
               state_d = RET;
            end
         end
         ENTER, RET: begin
            state_d     = DRAIN;
            drain_cnt_d = 3'(DRAIN_CYC);
         end
         DRAIN: begin
            if (drain_cnt_q <= 3'd1) begin
               state_d     = IDLE;
               drain_cnt_d = 3'd0;
            end else begin
               drain_cnt_d = drain_cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from state so an async reset zeroes them at once.
   assign bus.cp0_exc_we  = (state_q == ENTER);
   assign bus.epc_out     = (state_q == ENTER) ? epc_q  : 32'd0;
   assign bus.bd_out      = (state_q == ENTER) ? bd_q   : 1'b0;
   assign bus.exccode_out = (state_q == ENTER) ? code_q : 5'd0;
   assign bus.exl_clr     = (state_q == RET);
   assign bus.flush_all   = flush;
   assign bus.pc_redirect = (state_q == ENTER) || (state_q == RET);
   assign bus.redirect_pc = (state_q == ENTER) ? HANDLER_PC :
                            (state_q == RET)   ? bus.epc_cur : 32'd0;
   assign bus.busy        = flush;

endmodule

// File: tb/tb_bd_exc_ctrl.sv
// Bench for bd_exc_ctrl: vector table plus scoreboard of expected CP0/redirect strobes,
// and hand sequences for drain timing, stall hold, interrupt deferral and reset in DRAIN.
module tb_bd_exc_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bd_exc_ctrl_if bus ();

   bd_exc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  act;   // 0 none, 1 exception entry, 2 eret
      logic [31:0] epc;
      logic        bd;
      logic [4:0]  code;
      logic [31:0] redir;
   } exp_t;

   typedef struct {
      logic        bdm;
      logic        vm;
      logic        bde;
      logic        ve;
      logic [31:0] pcm;
      logic [31:0] pce;
      logic        exc;
      logic [4:0]  code;
      logic        eret;
      logic [5:0]  hwi;
      logic [5:0]  im;
      logic        ie;
      logic        exl;
      logic [31:0] epcc;
      logic [1:0]  act;
      logic [31:0] xepc;
      logic        xbd;
      logic [4:0]  xcode;
      logic [31:0] xredir;
   } vec_t;

   localparam int NV = 16;
   vec_t  vt [NV];
   exp_t  sb [$];
   exp_t  mon_e;
   int    checks = 0;
   int    errors = 0;
   logic  prev_strobe = 1'b0;
   logic  bseq [6];
   logic  fseq [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ev();
      bus.exc_M   = 1'b0;
      bus.eret_M  = 1'b0;
      bus.hw_int  = 6'h00;
      bus.BD_D    = 1'b0;
      bus.valid_D = 1'b0;
   endtask

   // Two unstalled shifts put (bdm,vm) into M and (bde,ve) into E.
   task automatic load_pipe(input logic bdm, input logic vm, input logic bde, input logic ve);
      clr_ev();
      bus.stall_E = 1'b0;
      bus.BD_D    = bdm;
      bus.valid_D = vm;
      tick();
      bus.BD_D    = bde;
      bus.valid_D = ve;
      tick();
      bus.BD_D    = 1'b0;
      bus.valid_D = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(bus.busy), 32'd0);
   endtask

   task automatic push_exp(input logic [1:0] a, input logic [31:0] e, input logic b,
                           input logic [4:0] c, input logic [31:0] r);
      exp_t x;
      x.act = a; x.epc = e; x.bd = b; x.code = c; x.redir = r;
      sb.push_back(x);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_we"},     32'(bus.cp0_exc_we),  32'd0);
      chk({tag, "_clr"},    32'(bus.exl_clr),     32'd0);
      chk({tag, "_flush"},  32'(bus.flush_all),   32'd0);
      chk({tag, "_redir"},  32'(bus.pc_redirect), 32'd0);
      chk({tag, "_rpc"},    bus.redirect_pc,      32'd0);
      chk({tag, "_busy"},   32'(bus.busy),        32'd0);
      chk({tag, "_epc"},    bus.epc_out,          32'd0);
   endtask

   // Scoreboard consumer: every CP0 strobe must match the oldest expected record.
   always @(negedge clk) begin
      if (!reset) begin
         prev_strobe = 1'b0;
      end else begin
         if (bus.cp0_exc_we || bus.exl_clr) begin
            chk("strobe_single", 32'(prev_strobe), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe actual=we%0b_clr%0b_epc%h required=none",
                        bus.cp0_exc_we, bus.exl_clr, bus.epc_out);
            end else begin
               mon_e = sb.pop_front();
               chk("kind_we",     32'(bus.cp0_exc_we),  32'(mon_e.act == 2'd1));
               chk("kind_clr",    32'(bus.exl_clr),     32'(mon_e.act == 2'd2));
               chk("redirect_pc", bus.redirect_pc,      mon_e.redir);
               chk("pc_redirect", 32'(bus.pc_redirect), 32'd1);
               chk("flush_strobe",32'(bus.flush_all),   32'd1);
               chk("busy_strobe", 32'(bus.busy),        32'd1);
               if (mon_e.act == 2'd1) begin
                  chk("epc_out",     bus.epc_out,          mon_e.epc);
                  chk("bd_out",      32'(bus.bd_out),      32'(mon_e.bd));
                  chk("exccode_out", 32'(bus.exccode_out), 32'(mon_e.code));
               end
            end
         end
         prev_strobe = bus.cp0_exc_we | bus.exl_clr | bus.pc_redirect;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          bdm  vm   bde  ve   PC_M          PC_E          exc  code   eret hw_int im     ie   exl  epc_cur       act  xepc          xbd  xcode  xredir
      vt[0]  = '{1'b0,1'b1,1'b0,1'b0,32'h0000_3010,32'h0000_0000,1'b1,5'd12,1'b0,6'h00,6'h3F,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_3010,1'b0,5'd12,32'h0000_4180};
      vt[1]  = '{1'b1,1'b1,1'b0,1'b0,32'h0000_3004,32'h0000_0000,1'b1,5'd4, 1'b0,6'h00,6'h3F,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_3000,1'b1,5'd4, 32'h0000_4180};
      vt[2]  = '{1'b0,1'b0,1'b0,1'b1,32'h0000_0000,32'h0000_3020,1'b0,5'd0, 1'b0,6'h01,6'h01,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_3020,1'b0,5'd0, 32'h0000_4180};
      vt[3]  = '{1'b0,1'b0,1'b0,1'b1,32'h0000_0000,32'h0000_3020,1'b0,5'd0, 1'b0,6'h01,6'h01,1'b1,1'b1,32'h0000_5000,2'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000};
      vt[4]  = '{1'b0,1'b1,1'b0,1'b1,32'h0000_3030,32'h0000_3034,1'b1,5'd10,1'b1,6'h3F,6'h3F,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_3030,1'b0,5'd10,32'h0000_4180};
      vt[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0000_3040,32'h0000_0000,1'b0,5'd0, 1'b1,6'h00,6'h3F,1'b1,1'b0,32'h0000_3044,2'd2,32'h0000_0000,1'b0,5'd0, 32'h0000_3044};
      vt[6]  = '{1'b1,1'b1,1'b0,1'b1,32'h0000_3050,32'h0000_3054,1'b0,5'd0, 1'b0,6'h04,6'h3F,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_304C,1'b1,5'd0, 32'h0000_4180};
      vt[7]  = '{1'b0,1'b0,1'b1,1'b1,32'h0000_0000,32'h0000_3060,1'b0,5'd0, 1'b0,6'h20,6'h20,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_305C,1'b1,5'd0, 32'h0000_4180};
      vt[8]  = '{1'b1,1'b1,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b1,5'd5, 1'b0,6'h00,6'h3F,1'b1,1'b0,32'h0000_5000,2'd1,32'hFFFF_FFFC,1'b1,5'd5, 32'h0000_4180};
      vt[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0000_3090,32'h0000_0000,1'b1,5'd12,1'b0,6'h00,6'h3F,1'b1,1'b0,32'h0000_5000,2'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000};
      vt[10] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_30A0,32'h0000_30A4,1'b0,5'd0, 1'b0,6'h02,6'h01,1'b1,1'b0,32'h0000_5000,2'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000};
      vt[11] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_30B0,32'h0000_30B4,1'b0,5'd0, 1'b0,6'h01,6'h01,1'b0,1'b0,32'h0000_5000,2'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000};
      vt[12] = '{1'b0,1'b0,1'b0,1'b1,32'h0000_30C0,32'h0000_30C4,1'b0,5'd0, 1'b1,6'h00,6'h3F,1'b1,1'b0,32'h0000_5000,2'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000};
      vt[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0000_30D0,32'h0000_30D4,1'b0,5'd0, 1'b0,6'h01,6'h01,1'b1,1'b0,32'h0000_5000,2'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000};
      vt[14] = '{1'b0,1'b1,1'b0,1'b1,32'h0000_3080,32'h0000_3084,1'b0,5'd0, 1'b1,6'h01,6'h01,1'b1,1'b0,32'h0000_5000,2'd1,32'h0000_3080,1'b0,5'd0, 32'h0000_4180};
      vt[15] = '{1'b0,1'b1,1'b0,1'b0,32'h0000_30E0,32'h0000_0000,1'b0,5'd0, 1'b1,6'h3F,6'h3F,1'b1,1'b1,32'h0000_3100,2'd2,32'h0000_0000,1'b0,5'd0, 32'h0000_3100};

      reset         = 1'b0;
      bus.stall_E   = 1'b0;
      bus.PC_M      = 32'd0;
      bus.PC_E      = 32'd0;
      bus.exccode_M = 5'd0;
      bus.im        = 6'h3F;
      bus.ie        = 1'b1;
      bus.exl       = 1'b0;
      bus.epc_cur   = 32'd0;
      clr_ev();
      repeat (2) @(negedge clk);
      chk_zero_outputs("reset");
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         load_pipe(vt[i].bdm, vt[i].vm, vt[i].bde, vt[i].ve);
         bus.PC_M      = vt[i].pcm;
         bus.PC_E      = vt[i].pce;
         bus.exc_M     = vt[i].exc;
         bus.exccode_M = vt[i].code;
         bus.eret_M    = vt[i].eret;
         bus.hw_int    = vt[i].hwi;
         bus.im        = vt[i].im;
         bus.ie        = vt[i].ie;
         bus.exl       = vt[i].exl;
         bus.epc_cur   = vt[i].epcc;
         if (vt[i].act != 2'd0)
            push_exp(vt[i].act, vt[i].xepc, vt[i].xbd, vt[i].xcode, vt[i].xredir);
         tick();
         clr_ev();
         wait_idle();
         chk("sb_drained", 32'(sb.size()), 32'd0);
      end
      bus.im  = 6'h3F;
      bus.ie  = 1'b1;
      bus.exl = 1'b0;

      // Entry timing: busy/flush for ENTER + DRAIN_CYC cycles; events during DRAIN are dropped.
      load_pipe(1'b0, 1'b1, 1'b0, 1'b0);
      bus.PC_M = 32'h0000_3200; bus.exc_M = 1'b1; bus.exccode_M = 5'd12;
      push_exp(2'd1, 32'h0000_3200, 1'b0, 5'd12, 32'h0000_4180);
      tick();
      clr_ev();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bseq[c] = bus.busy;
         fseq[c] = bus.flush_all;
         if (c == 1) begin
            bus.exc_M = 1'b1; bus.eret_M = 1'b1; bus.hw_int = 6'h3F; bus.valid_D = 1'b1;
         end
         if (c == 2) clr_ev();
      end
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("busy_cyc%0d", c),  32'(bseq[c]), 32'(c < 3));
         chk($sformatf("flush_cyc%0d", c), 32'(fseq[c]), 32'(c < 3));
      end
      chk("sb_after_drain", 32'(sb.size()), 32'd0);

      // Stall hold: bd_M must survive three stalled cycles of BD_D toggling.
      load_pipe(1'b1, 1'b1, 1'b0, 1'b1);
      bus.stall_E = 1'b1;
      bus.valid_D = 1'b1;
      bus.BD_D = 1'b0; tick();
      bus.BD_D = 1'b1; tick();
      bus.BD_D = 1'b0; tick();
      bus.PC_M = 32'h0000_3104; bus.exc_M = 1'b1; bus.exccode_M = 5'd12;
      push_exp(2'd1, 32'h0000_3100, 1'b1, 5'd12, 32'h0000_4180);
      tick();
      clr_ev();
      bus.stall_E = 1'b0;
      wait_idle();
      chk("sb_after_stall", 32'(sb.size()), 32'd0);

      // Interrupt with an empty pipe waits, then lands on the first valid E instruction.
      load_pipe(1'b0, 1'b0, 1'b0, 1'b0);
      bus.hw_int = 6'h01; bus.im = 6'h01; bus.ie = 1'b1; bus.exl = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("deferred_busy", 32'(bus.busy), 32'd0);
      bus.PC_E = 32'h0000_3070; bus.PC_M = 32'h0000_0000;
      bus.BD_D = 1'b0; bus.valid_D = 1'b1;
      push_exp(2'd1, 32'h0000_3070, 1'b0, 5'd0, 32'h0000_4180);
      tick();
      bus.valid_D = 1'b0;
      tick();
      clr_ev();
      bus.im = 6'h3F;
      wait_idle();
      chk("sb_after_defer", 32'(sb.size()), 32'd0);

      // Reset asserted during DRAIN drops everything immediately.
      load_pipe(1'b0, 1'b1, 1'b0, 1'b0);
      bus.PC_M = 32'h0000_3300; bus.exc_M = 1'b1; bus.exccode_M = 5'd3;
      push_exp(2'd1, 32'h0000_3300, 1'b0, 5'd3, 32'h0000_4180);
      tick();
      clr_ev();
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk_zero_outputs("rst_drain");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_busy",  32'(bus.busy),      32'd0);
      chk("post_rst_flush", 32'(bus.flush_all), 32'd0);
      chk("sb_final",       32'(sb.size()),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
